// File: rtl/matrix_mult_arbiter_pkg.sv
// Shared types and constants for the matrix multiplier arbiter.
package matrix_mult_arbiter_pkg;

    // Controller states; the encoding is shared with the multiplier-side tooling.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } arb_state_e;

    // The multiplier's ready output is stale for this many WAIT samples after a start.
    localparam int unsigned MIN_WAIT = 2;

    // Width of a binary index into n requesters (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_mult_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from last+1.
module matrix_mult_arbiter_rr_arbiter
    import matrix_mult_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [N_REQ-1:0] gnt_c_o,
    output logic [IW-1:0]    idx_c_o
);

    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    int unsigned pos;
    logic        found;

    // Rotate the search start to last+1 and take the first requester found.
    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        found   = 1'b0;
        pos     = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            pos = 32'(last_i) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!found && req_i[IW'(pos)]) begin
                found   = 1'b1;
                idx_c_o = IW'(pos);
                gnt_c_o = ONE << pos;
            end
        end
    end

endmodule

// File: rtl/matrix_mult_arbiter.sv
// Round-robin scheduler sharing one matrix multiplier among N_REQ requesters.
module matrix_mult_arbiter
    import matrix_mult_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ               = 4,
    parameter int unsigned FIRST_MATRIX_HEIGHT = 5,
    parameter int unsigned BOTH_MATRIX_W_H     = 5,
    parameter int unsigned SECOND_MATRIX_WIDTH = 5,
    parameter int unsigned DATA_WIDTH          = 8,
    parameter int unsigned TIMEOUT             = 15
) (
    input  logic                                                              clk,
    input  logic                                                              i_rst_n,
    input  logic [N_REQ-1:0]                                                  i_req,
    input  logic [N_REQ*FIRST_MATRIX_HEIGHT*BOTH_MATRIX_W_H*DATA_WIDTH-1:0]   i_matrix_1_bus,
    input  logic [N_REQ*SECOND_MATRIX_WIDTH*BOTH_MATRIX_W_H*DATA_WIDTH-1:0]   i_matrix_2_bus,
    input  logic [N_REQ-1:0]                                                  i_ack,
    output logic [N_REQ-1:0]                                                  o_grant,
    output logic [N_REQ-1:0]                                                  o_valid,
    output logic [FIRST_MATRIX_HEIGHT*SECOND_MATRIX_WIDTH*DATA_WIDTH-1:0]     o_result,
    output logic                                                              o_err,
    output logic                                                              o_busy,
    output logic                                                              o_mm_calc,
    output logic [FIRST_MATRIX_HEIGHT*BOTH_MATRIX_W_H*DATA_WIDTH-1:0]         o_mm_matrix_1,
    output logic [SECOND_MATRIX_WIDTH*BOTH_MATRIX_W_H*DATA_WIDTH-1:0]         o_mm_matrix_2,
    input  logic [FIRST_MATRIX_HEIGHT*SECOND_MATRIX_WIDTH*DATA_WIDTH-1:0]     i_mm_result,
    input  logic                                                              i_mm_ready
);

    localparam int unsigned M1_SIZE  = FIRST_MATRIX_HEIGHT * BOTH_MATRIX_W_H * DATA_WIDTH;
    localparam int unsigned M2_SIZE  = SECOND_MATRIX_WIDTH * BOTH_MATRIX_W_H * DATA_WIDTH;
    localparam int unsigned RES_SIZE = FIRST_MATRIX_HEIGHT * SECOND_MATRIX_WIDTH * DATA_WIDTH;
    localparam int unsigned IW       = idx_width(N_REQ);
    localparam int unsigned CW       = $clog2(TIMEOUT + 1);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        win_q, win_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [N_REQ-1:0]     valid_q, valid_d;
    logic [RES_SIZE-1:0]  result_q, result_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 calc_q, calc_d;
    logic [M1_SIZE-1:0]   m1_q, m1_d;
    logic [M2_SIZE-1:0]   m2_q, m2_d;

    logic [N_REQ-1:0]     arb_gnt;
    logic [IW-1:0]        arb_idx;

    matrix_mult_arbiter_rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_arbiter (
        .req_i   (i_req),
        .last_i  (last_q),
        .gnt_c_o (arb_gnt),
        .idx_c_o (arb_idx)
    );

    // Next-state, operand latch and result capture for the single shared job.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        grant_d  = '0;
        calc_d   = 1'b0;
        valid_d  = valid_q;
        result_d = result_q;
        err_d    = err_q;
        m1_d     = m1_q;
        m2_d     = m2_q;

        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    for (int unsigned r = 0; r < N_REQ; r++) begin
                        if (arb_idx == IW'(r)) begin
                            m1_d = i_matrix_1_bus[r*M1_SIZE +: M1_SIZE];
                            m2_d = i_matrix_2_bus[r*M2_SIZE +: M2_SIZE];
                        end
                    end
                    win_d   = arb_idx;
                    grant_d = arb_gnt;
                    calc_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if ((cnt_q >= CW'(MIN_WAIT)) && i_mm_ready) begin
                    result_d = i_mm_result;
                    err_d    = 1'b0;
                    valid_d  = ONE << win_q;
                    state_d  = ST_DELIVER;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    valid_d  = ONE << win_q;
                    state_d  = ST_DELIVER;
                end else begin
                    cnt_d = CW'(cnt_q + CW'(1));
                end
            end
            ST_DELIVER: begin
                if (i_ack[win_q]) begin
                    valid_d  = '0;
                    result_d = '0;
                    err_d    = 1'b0;
                    last_d   = win_q;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset restarts arbitration at requester 0.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            last_q   <= IW'(N_REQ - 1);
            win_q    <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            valid_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            calc_q   <= 1'b0;
            m1_q     <= '0;
            m2_q     <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            calc_q   <= calc_d;
            m1_q     <= m1_d;
            m2_q     <= m2_d;
        end
    end

    assign o_grant       = grant_q;
    assign o_valid       = valid_q;
    assign o_result      = result_q;
    assign o_err         = err_q;
    assign o_busy        = busy_q;
    assign o_mm_calc     = calc_q;
    assign o_mm_matrix_1 = m1_q;
    assign o_mm_matrix_2 = m2_q;

endmodule

// File: tb/tb_matrix_mult_arbiter.sv
// Self-checking bench for matrix_mult_arbiter with a job-level reference model.
module tb_matrix_mult_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned H   = 5;
    localparam int unsigned BW  = 5;
    localparam int unsigned SW  = 5;
    localparam int unsigned DW  = 8;
    localparam int unsigned TO  = 15;
    localparam int unsigned M1  = H * BW * DW;
    localparam int unsigned M2  = SW * BW * DW;
    localparam int unsigned RES = H * SW * DW;
    localparam int unsigned CKW = 200;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*M1-1:0]   m1_bus = '0;
    logic [N*M2-1:0]   m2_bus = '0;
    logic [N-1:0]      ack = '0;
    logic [N-1:0]      o_grant, o_valid;
    logic [RES-1:0]    o_result;
    logic              o_err, o_busy, o_mm_calc;
    logic [M1-1:0]     o_mm_matrix_1;
    logic [M2-1:0]     o_mm_matrix_2;
    logic [RES-1:0]    mm_result;
    logic              mm_ready;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    matrix_mult_arbiter #(
        .N_REQ(N), .FIRST_MATRIX_HEIGHT(H), .BOTH_MATRIX_W_H(BW),
        .SECOND_MATRIX_WIDTH(SW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .i_rst_n(rst_n), .i_req(req),
        .i_matrix_1_bus(m1_bus), .i_matrix_2_bus(m2_bus), .i_ack(ack),
        .o_grant(o_grant), .o_valid(o_valid), .o_result(o_result),
        .o_err(o_err), .o_busy(o_busy), .o_mm_calc(o_mm_calc),
        .o_mm_matrix_1(o_mm_matrix_1), .o_mm_matrix_2(o_mm_matrix_2),
        .i_mm_result(mm_result), .i_mm_ready(mm_ready)
    );

    task automatic chk(input string nm, input logic [CKW-1:0] act, input logic [CKW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    endtask

    // Row-major product: m1(i,k) at (i*BW+k), m2(k,j) at (k*SW+j), res(i,j) at (i*SW+j).
    function automatic logic [RES-1:0] matmul(input logic [M1-1:0] a, input logic [M2-1:0] b);
        logic [RES-1:0] r;
        int unsigned acc;
        r = '0;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < SW; j++) begin
                acc = 0;
                for (int k = 0; k < BW; k++)
                    acc += 32'(a[(i*BW+k)*DW +: DW]) * 32'(b[(k*SW+j)*DW +: DW]);
                r[(i*SW+j)*DW +: DW] = DW'(acc);
            end
        return r;
    endfunction

    // Multiplier stand-in: ready stale one edge after start, low the next, then high with result.
    logic stall = 1'b0;
    int   mm_stage;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_ready  <= 1'b1;
            mm_stage  <= 0;
            mm_result <= '0;
        end else if (o_mm_calc) begin
            mm_stage <= 1;
        end else if (mm_stage == 1) begin
            mm_ready  <= 1'b0;
            mm_result <= matmul(o_mm_matrix_1, o_mm_matrix_2);
            mm_stage  <= 2;
        end else if (mm_stage == 2 && !stall) begin
            mm_ready <= 1'b1;
            mm_stage <= 0;
        end
    end

    // Reference model: one job at a time, latency counted from the arbitration edge.
    bit             m_busy = 0, m_calc = 0, m_err = 0, m_vld = 0;
    int             m_w = 0, m_age = 0, m_last = N - 1;
    logic [N-1:0]   m_grant = '0;
    logic [RES-1:0] m_res = '0, m_prod = '0;
    logic [M1-1:0]  m_m1 = '0;
    logic [M2-1:0]  m_m2 = '0;

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (((r >> idx) & N'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_calc = 0; m_err = 0; m_vld = 0;
            m_w = 0; m_age = 0; m_last = N - 1;
            m_grant = '0; m_res = '0; m_m1 = '0; m_m2 = '0;
        end else begin
            m_grant = '0;
            m_calc  = 0;
            if (!m_busy) begin
                if (req != '0) begin
                    m_w     = pick(req, m_last);
                    m_busy  = 1;
                    m_age   = 0;
                    m_grant = N'(1) << m_w;
                    m_calc  = 1;
                    m_m1    = m1_bus[m_w*M1 +: M1];
                    m_m2    = m2_bus[m_w*M2 +: M2];
                    m_prod  = matmul(m_m1, m_m2);
                end
            end else if (!m_vld) begin
                m_age++;
                if (m_age >= 4 && mm_ready) begin
                    m_vld = 1; m_res = m_prod; m_err = 0;
                end else if (m_age == 2 + TO) begin
                    m_vld = 1; m_res = '0; m_err = 1;
                end
            end else if (ack[m_w]) begin
                m_vld = 0; m_res = '0; m_err = 0;
                m_last = m_w; m_busy = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("grant",  CKW'(o_grant),       CKW'(m_grant));
        chk("valid",  CKW'(o_valid),       CKW'(m_vld ? (N'(1) << m_w) : N'(0)));
        chk("result", CKW'(o_result),      CKW'(m_res));
        chk("err",    CKW'(o_err),         CKW'(m_err));
        chk("busy",   CKW'(o_busy),        CKW'(m_busy));
        chk("calc",   CKW'(o_mm_calc),     CKW'(m_calc));
        chk("mm_m1",  CKW'(o_mm_matrix_1), CKW'(m_m1));
        chk("mm_m2",  CKW'(o_mm_matrix_2), CKW'(m_m2));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (o_grant != '0) begin
                for (int b = 0; b < N; b++) if (((o_grant >> b) & N'(1)) != '0) idx = b;
                return;
            end
        end
        chk("grant_timeout", CKW'(0), CKW'(1));
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40; i++) begin
            if (o_valid != '0) return;
            step();
        end
        chk("valid_timeout", CKW'(0), CKW'(1));
    endtask

    task automatic ack_valid();
        ack = o_valid;
        step();
        ack = '0;
    endtask

    task automatic rand_ops(input int r);
        for (int e = 0; e < H * BW; e++) m1_bus[r*M1 + e*DW +: DW] = DW'($urandom);
        for (int e = 0; e < SW * BW; e++) m2_bus[r*M2 + e*DW +: DW] = DW'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [RES-1:0] all20;
    logic [M1-1:0]  all2;
    int g;

    initial begin
        for (int e = 0; e < H * SW; e++) all20[e*DW +: DW] = DW'(20);
        for (int e = 0; e < H * BW; e++) all2[e*DW +: DW] = DW'(2);
        #2;
        do_reset();

        // Idle after reset: nothing moves.
        for (int i = 0; i < 6; i++) begin
            step();
            chk("idle_busy",  CKW'(o_busy),  CKW'(0));
            chk("idle_valid", CKW'(o_valid), CKW'(0));
        end

        // Single request from requester 2 with all-2 operands.
        for (int r = 0; r < N; r++) rand_ops(r);
        m1_bus[2*M1 +: M1] = all2;
        m2_bus[2*M2 +: M2] = all2;
        req = 4'b0100;
        step();
        chk("single_grant", CKW'(o_grant), CKW'(4'b0100));
        chk("single_calc",  CKW'(o_mm_calc), CKW'(1));
        req = '0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("single_early_valid", CKW'(o_valid), CKW'(0));
        end
        step();
        chk("single_valid",  CKW'(o_valid),  CKW'(4'b0100));
        chk("single_result", CKW'(o_result), CKW'(all20));
        ack = 4'b0100;
        step();
        ack = '0;
        chk("single_ack_clr", CKW'(o_valid), CKW'(0));

        // All requesters held: rotation from a fresh reset.
        do_reset();
        for (int r = 0; r < N; r++) rand_ops(r);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_grant(g);
            chk("rr_order", CKW'(g), CKW'(j % N));
            if (j == 4) req = '0;
            wait_valid();
            ack_valid();
        end

        // Wrong-bit ack is ignored; last is 0 so requester 1 wins.
        rand_ops(1);
        req = 4'b0010;
        wait_grant(g);
        req = '0;
        wait_valid();
        ack = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wrong_ack_hold", CKW'(o_valid), CKW'(4'b0010));
        end
        ack = 4'b0010;
        step();
        ack = '0;
        chk("right_ack_clr", CKW'(o_valid), CKW'(0));

        // Timeout: multiplier never becomes ready again.
        stall = 1'b1;
        rand_ops(0);
        req = 4'b0001;
        wait_grant(g);
        chk("to_grant", CKW'(g), CKW'(0));
        req = '0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("to_early_valid", CKW'(o_valid), CKW'(0));
        end
        step();
        chk("to_valid",  CKW'(o_valid),  CKW'(4'b0001));
        chk("to_err",    CKW'(o_err),    CKW'(1));
        chk("to_result", CKW'(o_result), CKW'(0));
        stall = 1'b0;
        ack_valid();
        rand_ops(3);
        req = 4'b1000;
        wait_grant(g);
        req = '0;
        wait_valid();
        chk("after_to_err", CKW'(o_err), CKW'(0));
        ack_valid();

        // Reset during WAIT clears everything asynchronously.
        req = 4'b0100;
        wait_grant(g);
        req = '0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_busy",  CKW'(o_busy),        CKW'(0));
        chk("rst_valid", CKW'(o_valid),       CKW'(0));
        chk("rst_m1",    CKW'(o_mm_matrix_1), CKW'(0));
        step();
        rst_n = 1'b1;
        req = 4'b1111;
        wait_grant(g);
        chk("rst_first_grant", CKW'(g), CKW'(0));
        req = '0;
        wait_valid();
        ack_valid();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            for (int r = 0; r < N; r++) begin
                if (((o_grant >> r) & N'(1)) != '0) begin
                    req[r] = 1'($urandom % 2);
                    rand_ops(r);
                end else if (!req[r] && ($urandom % 4 == 0)) begin
                    rand_ops(r);
                    req[r] = 1'b1;
                end
            end
            if (o_valid != '0)
                ack = ($urandom % 3 == 0) ? o_valid : (N'($urandom) & ~o_valid);
            else
                ack = N'($urandom);
            if ($urandom % 60 == 0) stall = ~stall;
            step();
        end

        // Drain.
        req = '0;
        stall = 1'b0;
        for (int i = 0; i < 60; i++) begin
            ack = o_valid;
            step();
        end
        ack = '0;
        step();
        chk("drain_busy", CKW'(o_busy), CKW'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
